// File: rtl/pixel_bit_serializer_if.sv
// pixel_bit_serializer_if
//   Bundles the frame control, pixel memory read port and bit stream
//   handshake of the pixel bit serializer.
//   master : the serializer itself (drives busy, pix_rd, pix_addr,
//            bit_to_transmit, all_bits_shifted)
//   slave  : the surrounding system (pixel memory, prescaler_selector,
//            frame sequencer)
//   Parameters: ADDR_W pixel address width, BITS_PER_LED pixel word width.
interface pixel_bit_serializer_if #(
  parameter int ADDR_W       = 3,
  parameter int BITS_PER_LED = 24
);
  logic                    frame_start;
  logic                    busy;
  logic                    pix_rd;
  logic [ADDR_W-1:0]       pix_addr;
  logic [BITS_PER_LED-1:0] pix_data;
  logic                    new_bit_rqst;
  logic                    bit_to_transmit;
  logic                    all_bits_shifted;
  logic                    reset_finish;

  modport master (
    input  frame_start, pix_data, new_bit_rqst, reset_finish,
    output busy, pix_rd, pix_addr, bit_to_transmit, all_bits_shifted
  );

  modport slave (
    output frame_start, pix_data, new_bit_rqst, reset_finish,
    input  busy, pix_rd, pix_addr, bit_to_transmit, all_bits_shifted
  );
endinterface

// File: rtl/pixel_bit_serializer.sv
// pixel_bit_serializer
//   Fetches GRB pixel words from the pixel memory and serialises them
//   MSB-first, one bit per new_bit_rqst pulse. After the last bit of the
//   last LED it raises all_bits_shifted and waits for reset_finish before
//   accepting another frame.
// Ports
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : pixel_bit_serializer_if master modport
//          frame_start (in)       start a frame, honoured in IDLE only
//          busy (out)             frame in progress
//          pix_rd/pix_addr (out)  pixel memory read strobe and LED index
//          pix_data (in)          read data, valid 1 cycle after pix_rd
//          new_bit_rqst (in)      current bit consumed
//          bit_to_transmit (out)  current bit
//          all_bits_shifted (out) frame fully shifted
//          reset_finish (in)      stripe latch period over
module pixel_bit_serializer #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int ADDR_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  pixel_bit_serializer_if.master bus
);

  localparam int CNT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BITS_PER_LED - 1);
  localparam logic [ADDR_W-1:0] LAST_LED = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                  state;
  logic [BITS_PER_LED-1:0] shift_reg;
  logic [BITS_PER_LED-1:0] next_pix;
  logic [CNT_W-1:0]        bit_cnt;
  logic [ADDR_W-1:0]       led_cnt;
  logic                    busy;
  logic                    pix_rd;
  logic [ADDR_W-1:0]       pix_addr;
  logic                    all_bits_shifted;
  // High in the cycle pix_data carries the answer to the previous pix_rd.
  logic                    data_valid;

  // Single FSM register block. pix_rd is a one-cycle strobe, so it
  // defaults low every cycle and is only raised where a read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      shift_reg        <= '0;
      next_pix         <= '0;
      bit_cnt          <= '0;
      led_cnt          <= '0;
      busy             <= 1'b0;
      pix_rd           <= 1'b0;
      pix_addr         <= '0;
      all_bits_shifted <= 1'b0;
      data_valid       <= 1'b0;
    end else begin
      pix_rd     <= 1'b0;
      data_valid <= pix_rd;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state    <= LOAD;
            pix_rd   <= 1'b1;
            pix_addr <= '0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          // Wait for the read data of LED 0, then prefetch LED 1 while
          // LED 0 is being shifted out.
          if (data_valid) begin
            shift_reg <= bus.pix_data;
            bit_cnt   <= '0;
            led_cnt   <= '0;
            state     <= SHIFT;
            if (NUM_LEDS > 1) begin
              pix_rd   <= 1'b1;
              pix_addr <= ADDR_W'(1);
            end
          end
        end
        SHIFT: begin
          if (data_valid) begin
            next_pix <= bus.pix_data;
          end
          if (bus.new_bit_rqst) begin
            if (bit_cnt != LAST_BIT) begin
              shift_reg <= shift_reg << 1;
              bit_cnt   <= bit_cnt + 1'b1;
            end else if (led_cnt != LAST_LED) begin
              // Swap in the prefetched word and fetch the one after it.
              shift_reg <= next_pix;
              bit_cnt   <= '0;
              led_cnt   <= led_cnt + 1'b1;
              if (int'(led_cnt) + 2 < NUM_LEDS) begin
                pix_rd   <= 1'b1;
                pix_addr <= ADDR_W'(int'(led_cnt) + 2);
              end
            end else begin
              state            <= DONE;
              all_bits_shifted <= 1'b1;
            end
          end
        end
        DONE: begin
          // frame_start arriving together with reset_finish is dropped
          // because IDLE is only reached on the following edge.
          if (bus.reset_finish) begin
            state            <= IDLE;
            all_bits_shifted <= 1'b0;
            busy             <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The bit is only meaningful while shifting; it reads 0 everywhere else
  // so a stale word never leaks onto the stripe.
  assign bus.bit_to_transmit  = (state == SHIFT) & shift_reg[BITS_PER_LED-1];
  assign bus.busy             = busy;
  assign bus.pix_rd           = pix_rd;
  assign bus.pix_addr         = pix_addr;
  assign bus.all_bits_shifted = all_bits_shifted;

endmodule

// File: tb/tb_pixel_bit_serializer.sv
// tb_pixel_bit_serializer
//   Scoreboard bench for pixel_bit_serializer with two LEDs. Each frame
//   pushes its expected bit stream into a queue; a monitor pops one entry
//   per new_bit_rqst and checks the bit consumed plus the bit (or the
//   all_bits_shifted flag) visible on the following cycle.
module tb_pixel_bit_serializer;

  logic clk;
  logic rst;

  pixel_bit_serializer_if #(.ADDR_W(1), .BITS_PER_LED(24)) bus_if ();

  pixel_bit_serializer #(
    .NUM_LEDS    (2),
    .BITS_PER_LED(24),
    .ADDR_W      (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct {
    logic b;
    bit   last;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] mem[2];
  int          total;
  int          bad;
  int          rd_count;
  bit          post_check;
  bit          post_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel memory: registered read, data valid the cycle after pix_rd.
  // Outside that cycle it drives a junk pattern.
  always @(posedge clk) begin
    if (bus_if.pix_rd) bus_if.pix_data <= mem[bus_if.pix_addr];
    else               bus_if.pix_data <= 24'h5A5A5A;
  end

  always @(negedge clk) begin
    if (bus_if.pix_rd) rd_count = rd_count + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consume one expected bit per request, then check the cycle after.
  always @(negedge clk) begin
    exp_t e;
    if (post_check) begin
      post_check = 1'b0;
      if (post_last) begin
        checkOutput("abs_rise", {31'd0, bus_if.all_bits_shifted}, 32'd1);
        checkOutput("done_bit", {31'd0, bus_if.bit_to_transmit}, 32'd0);
      end else begin
        checkOutput("abs_low", {31'd0, bus_if.all_bits_shifted}, 32'd0);
        if (sb.size() > 0)
          checkOutput("next_bit", {31'd0, bus_if.bit_to_transmit}, {31'd0, sb[0].b});
      end
    end
    if (!rst && bus_if.new_bit_rqst && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("stream_bit", {31'd0, bus_if.bit_to_transmit}, {31'd0, e.b});
      post_check = 1'b1;
      post_last  = e.last;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseRqst();
    bus_if.new_bit_rqst = 1'b1;
    tick(1);
    bus_if.new_bit_rqst = 1'b0;
  endtask

  task automatic pulseResetFinish();
    bus_if.reset_finish = 1'b1;
    tick(1);
    bus_if.reset_finish = 1'b0;
    checkOutput("rf_abs_clear", {31'd0, bus_if.all_bits_shifted}, 32'd0);
    checkOutput("rf_busy_clear", {31'd0, bus_if.busy}, 32'd0);
  endtask

  // One frame: load memory, queue the expected bits, start, then request.
  task automatic applyStimulus(input logic [23:0] m0, input logic [23:0] m1,
                               input int spacing, input int nreq,
                               input bit restart_glitch);
    logic [47:0] stream;
    exp_t        e;
    mem[0] = m0;
    mem[1] = m1;
    stream = {m0, m1};
    for (int i = 0; i < nreq; i++) begin
      e.b    = stream[47-i];
      e.last = (i == 47);
      sb.push_back(e);
    end
    rd_count = 0;
    bus_if.frame_start = 1'b1;
    tick(1);
    bus_if.frame_start = 1'b0;
    checkOutput("start_rd", {31'd0, bus_if.pix_rd}, 32'd1);
    checkOutput("start_addr", {31'd0, bus_if.pix_addr}, 32'd0);
    checkOutput("start_busy", {31'd0, bus_if.busy}, 32'd1);
    tick(5);
    for (int i = 0; i < nreq; i++) begin
      pulseRqst();
      if (restart_glitch && i == 5) begin
        bus_if.frame_start = 1'b1;
        tick(1);
        bus_if.frame_start = 1'b0;
        tick(spacing - 2);
      end else begin
        tick(spacing - 1);
      end
    end
    tick(2);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rd_count = 0;
    post_check = 1'b0;
    post_last = 1'b0;
    mem[0] = '0;
    mem[1] = '0;
    bus_if.frame_start = 1'b0;
    bus_if.new_bit_rqst = 1'b0;
    bus_if.reset_finish = 1'b0;
    bus_if.pix_data = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("rst_rd", {31'd0, bus_if.pix_rd}, 32'd0);
    checkOutput("rst_addr", {31'd0, bus_if.pix_addr}, 32'd0);
    checkOutput("rst_bit", {31'd0, bus_if.bit_to_transmit}, 32'd0);
    checkOutput("rst_abs", {31'd0, bus_if.all_bits_shifted}, 32'd0);

    $display("[TB] requests while idle");
    for (int i = 0; i < 3; i++) begin
      pulseRqst();
      tick(2);
    end
    checkOutput("idle_busy", {31'd0, bus_if.busy}, 32'd0);

    $display("[TB] frame FF0000 / 00A5C3, spacing 12");
    applyStimulus(24'hFF0000, 24'h00A5C3, 12, 48, 1'b0);
    checkOutput("rd_count_f1", rd_count, 32'd2);

    $display("[TB] hold in DONE");
    for (int i = 0; i < 10; i++) begin
      pulseRqst();
      tick(9);
      checkOutput("hold_abs", {31'd0, bus_if.all_bits_shifted}, 32'd1);
      checkOutput("hold_bit", {31'd0, bus_if.bit_to_transmit}, 32'd0);
      checkOutput("hold_busy", {31'd0, bus_if.busy}, 32'd1);
    end
    pulseResetFinish();

    $display("[TB] frame with ignored restart during shift");
    applyStimulus(24'hC3A55A, 24'h0F0F01, 5, 48, 1'b1);
    checkOutput("rd_count_f2", rd_count, 32'd2);
    bus_if.frame_start = 1'b1;
    bus_if.reset_finish = 1'b1;
    tick(1);
    bus_if.frame_start = 1'b0;
    bus_if.reset_finish = 1'b0;
    checkOutput("simul_busy", {31'd0, bus_if.busy}, 32'd0);
    tick(1);
    checkOutput("simul_dropped_busy", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("simul_dropped_rd", {31'd0, bus_if.pix_rd}, 32'd0);

    $display("[TB] minimum request spacing");
    applyStimulus(24'h123456, 24'h80F00F, 3, 48, 1'b0);
    checkOutput("rd_count_f3", rd_count, 32'd2);
    pulseResetFinish();

    $display("[TB] reset at bit 10 of LED1");
    applyStimulus(24'hA0A0A0, 24'h5B5B5B, 4, 34, 1'b0);
    checkOutput("abort_busy_before", {31'd0, bus_if.busy}, 32'd1);
    #3 rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("abort_rd", {31'd0, bus_if.pix_rd}, 32'd0);
    checkOutput("abort_addr", {31'd0, bus_if.pix_addr}, 32'd0);
    checkOutput("abort_bit", {31'd0, bus_if.bit_to_transmit}, 32'd0);
    checkOutput("abort_abs", {31'd0, bus_if.all_bits_shifted}, 32'd0);
    sb.delete();
    tick(2);
    rst = 1'b0;
    tick(2);
    applyStimulus(24'h3C96E1, 24'hFFFFFE, 4, 48, 1'b0);
    checkOutput("rd_count_f4", rd_count, 32'd2);
    pulseResetFinish();

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
